// File: rtl/apb_slave_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : apb_slave_regfile
// Description : APB completer with a word-addressed register file,
//               programmable wait states, byte strobes and error response.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_regfile #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic                  pclk_i,
    input  logic                  prst_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [DATA_WIDTH-1:0] pwdata_i,
    input  logic [3:0]            pstrb_i,
    output logic                  pready_o,
    output logic [DATA_WIDTH-1:0] prdata_o,
    output logic                  pslverr_o
);

    localparam int c_IDX_W  = $clog2(NUM_REGS);
    localparam int c_HI_LSB = 2 + c_IDX_W;
    localparam logic [3:0] c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_READY = 2'd2;

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic [c_IDX_W-1:0]    r_idx;
    logic                  r_write;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_strb;
    logic                  r_pready;
    logic                  r_pslverr;
    logic [DATA_WIDTH-1:0] r_prdata;

    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_err;
    logic                  w_commit;
    logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];

    // Decode of the address presented in the setup cycle; latched on acceptance.
    assign w_idx = paddr_i[c_HI_LSB-1:2];
    assign w_err = (paddr_i[1:0] != 2'b00)
                 || (paddr_i[ADDR_WIDTH-1:c_HI_LSB] != '0)
                 || (pwrite_i && (w_idx == '0));

    // A write lands only on the edge that closes a non-aborted completion cycle.
    assign w_commit = (r_state == c_READY) && psel_i && penable_i && r_write && !r_err;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_id
                assign w_regs[gi] = ID_VALUE;
            end else begin : g_rw
                logic [DATA_WIDTH-1:0] r_q;
                always_ff @(posedge pclk_i) begin
                    if (prst_i) begin
                        r_q <= '0;
                    end else if (w_commit && (r_idx == c_IDX_W'(gi))) begin
                        for (int b = 0; b < 4; b++) begin
                            if (r_strb[b]) begin
                                r_q[8*b +: 8] <= r_wdata[8*b +: 8];
                            end
                        end
                    end
                end
                assign w_regs[gi] = r_q;
            end
        end
    endgenerate

    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            r_state   <= c_IDLE;
            r_cnt     <= 4'd0;
            r_idx     <= '0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_wdata   <= '0;
            r_strb    <= 4'd0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (psel_i && !penable_i) begin
                        r_idx   <= w_idx;
                        r_write <= pwrite_i;
                        r_wdata <= pwdata_i;
                        r_strb  <= pstrb_i;
                        r_err   <= w_err;
                        if (WAIT_STATES == 0) begin
                            r_state   <= c_READY;
                            r_pready  <= 1'b1;
                            r_pslverr <= w_err;
                            r_prdata  <= (pwrite_i || w_err) ? '0 : w_regs[w_idx];
                        end else begin
                            r_state <= c_WAIT;
                            r_cnt   <= c_WAIT_LOAD;
                        end
                    end
                end
                c_WAIT: begin
                    if (!psel_i) begin
                        r_state <= c_IDLE;
                    end else if (penable_i) begin
                        if (r_cnt == 4'd0) begin
                            r_state   <= c_READY;
                            r_pready  <= 1'b1;
                            r_pslverr <= r_err;
                            r_prdata  <= (r_write || r_err) ? '0 : w_regs[r_idx];
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                end
                c_READY: begin
                    r_state   <= c_IDLE;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_prdata  <= '0;
                end
                default: begin
                    r_state   <= c_IDLE;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_prdata  <= '0;
                end
            endcase
        end
    end

    assign pready_o  = r_pready;
    assign pslverr_o = r_pslverr;
    assign prdata_o  = r_prdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_apb_slave_regfile
// Description : Self-checking bench; drives a zero-wait and a 3-wait instance
//               against a byte-level register model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_slave_regfile;

    localparam logic [31:0] c_ID = 32'hA9B0_0001;

    logic        pclk = 1'b0;
    logic        prst;
    logic [31:0] paddr, pwdata;
    logic        psel0, psel3, penable, pwrite;
    logic [3:0]  pstrb;
    logic        pready0, pready3, pslverr0, pslverr3;
    logic [31:0] prdata0, prdata3;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model0 [16];
    logic [31:0] model3 [16];

    always #5 pclk = ~pclk;

    apb_slave_regfile #(.WAIT_STATES(0)) dut0 (
        .pclk_i(pclk), .prst_i(prst), .paddr_i(paddr), .psel_i(psel0),
        .penable_i(penable), .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .pready_o(pready0), .prdata_o(prdata0), .pslverr_o(pslverr0)
    );

    apb_slave_regfile #(.WAIT_STATES(3)) dut3 (
        .pclk_i(pclk), .prst_i(prst), .paddr_i(paddr), .psel_i(psel3),
        .penable_i(penable), .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .pready_o(pready3), .prdata_o(prdata3), .pslverr_o(pslverr3)
    );

    // Error rule for a 16-register map: misaligned, beyond 0x3C, or a write to the ID word.
    function automatic logic exp_err(input logic [31:0] a, input logic w);
        return (a[1:0] != 2'b00) || (a[31:6] != 26'd0) || (w && (a[5:2] == 4'd0));
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
        if (a[5:2] == 4'd0) return c_ID;
        return (d == 3) ? model3[a[5:2]] : model0[a[5:2]];
    endfunction

    task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] data,
                               input logic [3:0] s);
        logic [31:0] v;
        if (exp_err(a, 1'b1)) return;
        v = (d == 3) ? model3[a[5:2]] : model0[a[5:2]];
        for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = data[8*b +: 8];
        if (d == 3) model3[a[5:2]] = v; else model0[a[5:2]] = v;
    endtask

    task automatic go_idle();
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    // Bus driver: called #1 after a rising edge; returns #1 after the completion edge.
    task automatic apb_xfer(input int d, input logic [31:0] a, input logic w,
                            input logic [31:0] data, input logic [3:0] s, input bit keep,
                            output logic [31:0] rd, output logic err, output int cyc);
        bit seen;
        paddr = a; pwrite = w; pwdata = data; pstrb = s; penable = 1'b0;
        if (d == 3) psel3 = 1'b1; else psel0 = 1'b1;
        @(posedge pclk); #1;
        penable = 1'b1;
        cyc = 0; seen = 1'b0; rd = 32'hx; err = 1'bx;
        while (!seen && cyc < 40) begin
            @(negedge pclk);
            cyc++;
            if (((d == 3) ? pready3 : pready0) === 1'b1) begin
                seen = 1'b1;
                rd   = (d == 3) ? prdata3 : prdata0;
                err  = (d == 3) ? pslverr3 : pslverr0;
            end else begin
                n_checks++;
                if (((d == 3) ? prdata3 : prdata0) !== 32'd0 || ((d == 3) ? pslverr3 : pslverr0) !== 1'b0) begin
                    n_errors++;
                    $display("FAIL wait_outputs dut%0d addr=%h: prdata=%h pslverr=%b, required 0/0", d, a,
                             (d == 3) ? prdata3 : prdata0, (d == 3) ? pslverr3 : pslverr0);
                end
                @(posedge pclk); #1;
            end
        end
        if (!seen) begin
            n_checks++; n_errors++;
            $display("FAIL timeout dut%0d addr=%h: no pready within 40 cycles, required completion", d, a);
        end
        @(posedge pclk); #1;
        if (!keep) go_idle();
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic err; int cyc;
        prst = 1'b1; go_idle(); paddr = '0; pwrite = 1'b0; pwdata = '0; pstrb = '0;
        repeat (3) @(posedge pclk); #1;
        prst = 1'b0;
        for (int i = 0; i < 16; i++) begin model0[i] = '0; model3[i] = '0; end
        n_checks++;
        if ({pready0, pslverr0, prdata0} !== 34'd0) begin
            n_errors++; $display("FAIL reset_out dut0: got %b/%b/%h, required 0/0/0", pready0, pslverr0, prdata0);
        end
        n_checks++;
        if ({pready3, pslverr3, prdata3} !== 34'd0) begin
            n_errors++; $display("FAIL reset_out dut3: got %b/%b/%h, required 0/0/0", pready3, pslverr3, prdata3);
        end
        // Start a write of idx 3 on both, then reset during its access phase.
        paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'h1234_5678; pstrb = 4'hF;
        psel0 = 1'b1; psel3 = 1'b1; penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        prst = 1'b1;
        repeat (2) @(posedge pclk); #1;
        n_checks++;
        if ({pready0, pslverr0, prdata0, pready3, pslverr3, prdata3} !== 68'd0) begin
            n_errors++; $display("FAIL reset_midxfer: got %b/%b/%h %b/%b/%h, required all 0",
                                 pready0, pslverr0, prdata0, pready3, pslverr3, prdata3);
        end
        prst = 1'b0; go_idle();
        @(posedge pclk); #1;
        apb_xfer(0, 32'h0C, 1'b0, '0, 4'h0, 1'b0, rd, err, cyc);
        n_checks++;
        if (rd !== 32'd0 || err !== 1'b0) begin
            n_errors++; $display("FAIL reset_read3 dut0: got %h err=%b, required 0 err=0", rd, err);
        end
        apb_xfer(3, 32'h0C, 1'b0, '0, 4'h0, 1'b0, rd, err, cyc);
        n_checks++;
        if (rd !== 32'd0 || err !== 1'b0) begin
            n_errors++; $display("FAIL reset_read3 dut3: got %h err=%b, required 0 err=0", rd, err);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; logic err; int cyc;
        apb_xfer(0, 32'h0C, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, err, cyc);
        model_write(0, 32'h0C, 32'hDEAD_BEEF, 4'hF);
        n_checks++;
        if (err !== 1'b0 || cyc != 1) begin
            n_errors++; $display("FAIL zw_write: err=%b cycles=%0d, required err=0 cycles=1", err, cyc);
        end
        apb_xfer(0, 32'h0C, 1'b0, '0, 4'h0, 1'b0, rd, err, cyc);
        n_checks++;
        if (rd !== 32'hDEAD_BEEF || err !== 1'b0 || cyc != 1) begin
            n_errors++; $display("FAIL zw_read: got %h err=%b cycles=%0d, required DEADBEEF err=0 cycles=1", rd, err, cyc);
        end
    endtask

    task automatic test_strobes();
        logic [31:0] rd; logic err; int cyc;
        apb_xfer(0, 32'h0C, 1'b1, 32'h1122_3344, 4'b0101, 1'b0, rd, err, cyc);
        model_write(0, 32'h0C, 32'h1122_3344, 4'b0101);
        apb_xfer(0, 32'h0C, 1'b0, '0, 4'h0, 1'b0, rd, err, cyc);
        n_checks++;
        if (rd !== 32'hDE22_BE44) begin
            n_errors++; $display("FAIL strb_0101: got %h, required DE22BE44", rd);
        end
        apb_xfer(0, 32'h0C, 1'b1, 32'h5555_AAAA, 4'b0000, 1'b0, rd, err, cyc);
        n_checks++;
        if (err !== 1'b0) begin
            n_errors++; $display("FAIL strb_zero_err: got %b, required 0", err);
        end
        apb_xfer(0, 32'h0C, 1'b0, '0, 4'hF, 1'b0, rd, err, cyc);
        n_checks++;
        if (rd !== 32'hDE22_BE44) begin
            n_errors++; $display("FAIL strb_zero_read: got %h, required DE22BE44", rd);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic err; int cyc;
        apb_xfer(3, 32'h00, 1'b0, '0, 4'h0, 1'b0, rd, err, cyc);
        n_checks++;
        if (rd !== c_ID || err !== 1'b0 || cyc != 4) begin
            n_errors++; $display("FAIL ws3_read_id: got %h err=%b cycles=%0d, required %h err=0 cycles=4", rd, err, cyc, c_ID);
        end
        apb_xfer(3, 32'h14, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b0, rd, err, cyc);
        model_write(3, 32'h14, 32'hCAFE_F00D, 4'hF);
        apb_xfer(3, 32'h14, 1'b0, '0, 4'h0, 1'b0, rd, err, cyc);
        n_checks++;
        if (rd !== 32'hCAFE_F00D || cyc != 4) begin
            n_errors++; $display("FAIL ws3_rw: got %h cycles=%0d, required CAFEF00D cycles=4", rd, cyc);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int cyc;
        for (int k = 0; k < 2; k++) begin
            int d;
            d = (k == 0) ? 0 : 3;
            apb_xfer(d, 32'h00, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, err, cyc);
            n_checks++;
            if (err !== 1'b1) begin
                n_errors++; $display("FAIL err_wr_id dut%0d: pslverr=%b, required 1", d, err);
            end
            apb_xfer(d, 32'h00, 1'b0, '0, 4'h0, 1'b0, rd, err, cyc);
            n_checks++;
            if (rd !== c_ID || err !== 1'b0) begin
                n_errors++; $display("FAIL err_id_intact dut%0d: got %h err=%b, required %h err=0", d, rd, err, c_ID);
            end
            apb_xfer(d, 32'h42, 1'b0, '0, 4'h0, 1'b0, rd, err, cyc);
            n_checks++;
            if (rd !== 32'd0 || err !== 1'b1) begin
                n_errors++; $display("FAIL err_misalign dut%0d: got %h err=%b, required 0 err=1", d, rd, err);
            end
            apb_xfer(d, 32'h40, 1'b0, '0, 4'h0, 1'b0, rd, err, cyc);
            n_checks++;
            if (rd !== 32'd0 || err !== 1'b1) begin
                n_errors++; $display("FAIL err_range dut%0d: got %h err=%b, required 0 err=1", d, rd, err);
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err; int cyc;
        apb_xfer(3, 32'h08, 1'b1, 32'h0BAD_0BAD, 4'hF, 1'b0, rd, err, cyc);
        model_write(3, 32'h08, 32'h0BAD_0BAD, 4'hF);
        // Abort a write on the wait-state slave during its WAIT phase.
        paddr = 32'h08; pwrite = 1'b1; pwdata = 32'h7777_7777; pstrb = 4'hF;
        psel3 = 1'b1; penable = 1'b0;
        @(posedge pclk); #1; penable = 1'b1;
        @(posedge pclk); #1; go_idle();
        @(posedge pclk); #1;
        n_checks++;
        if (pready3 !== 1'b0 || prdata3 !== 32'd0 || pslverr3 !== 1'b0) begin
            n_errors++; $display("FAIL abort_out dut3: got %b/%h/%b, required 0/0/0", pready3, prdata3, pslverr3);
        end
        apb_xfer(3, 32'h08, 1'b0, '0, 4'h0, 1'b0, rd, err, cyc);
        n_checks++;
        if (rd !== model_read(3, 32'h08)) begin
            n_errors++; $display("FAIL abort_wait_reg dut3: got %h, required %h", rd, model_read(3, 32'h08));
        end
        // Abort on the zero-wait slave while its completion cycle is showing.
        paddr = 32'h08; pwrite = 1'b1; pwdata = 32'h6666_6666; pstrb = 4'hF;
        psel0 = 1'b1; penable = 1'b0;
        @(posedge pclk); #1; go_idle();
        @(posedge pclk); #1;
        n_checks++;
        if (pready0 !== 1'b0) begin
            n_errors++; $display("FAIL abort_out dut0: pready=%b, required 0", pready0);
        end
        apb_xfer(0, 32'h08, 1'b0, '0, 4'h0, 1'b0, rd, err, cyc);
        n_checks++;
        if (rd !== model_read(0, 32'h08)) begin
            n_errors++; $display("FAIL abort_ready_reg dut0: got %h, required %h", rd, model_read(0, 32'h08));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int cyc;
        for (int k = 0; k < 2; k++) begin
            int d;
            d = (k == 0) ? 0 : 3;
            apb_xfer(d, 32'h10, 1'b1, 32'hA1A2_A3A4, 4'hF, 1'b1, rd, err, cyc);
            apb_xfer(d, 32'h18, 1'b1, 32'hB1B2_B3B4, 4'hF, 1'b1, rd, err, cyc);
            model_write(d, 32'h10, 32'hA1A2_A3A4, 4'hF);
            model_write(d, 32'h18, 32'hB1B2_B3B4, 4'hF);
            apb_xfer(d, 32'h10, 1'b0, '0, 4'h0, 1'b1, rd, err, cyc);
            n_checks++;
            if (rd !== 32'hA1A2_A3A4) begin
                n_errors++; $display("FAIL b2b_first dut%0d: got %h, required A1A2A3A4", d, rd);
            end
            apb_xfer(d, 32'h18, 1'b0, '0, 4'h0, 1'b0, rd, err, cyc);
            n_checks++;
            if (rd !== 32'hB1B2_B3B4) begin
                n_errors++; $display("FAIL b2b_second dut%0d: got %h, required B1B2B3B4", d, rd);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, data; logic err, w; logic [3:0] s; int cyc, d;
        for (int burst = 0; burst < 20; burst++) begin
            d = ($urandom_range(0, 1) == 0) ? 0 : 3;
            for (int t = 0; t < 4; t++) begin
                a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                case ($urandom_range(0, 7))
                    0: a[1:0] = 2'($urandom_range(1, 3));
                    1: a[$urandom_range(6, 31)] = 1'b1;
                    default: ;
                endcase
                w = 1'($urandom_range(0, 1));
                data = $urandom;
                s = 4'($urandom_range(0, 15));
                apb_xfer(d, a, w, data, s, (t != 3) && ($urandom_range(0, 1) == 1), rd, err, cyc);
                n_checks++;
                if (err !== exp_err(a, w) || cyc != ((d == 3) ? 4 : 1)) begin
                    n_errors++; $display("FAIL rnd_resp dut%0d addr=%h w=%b: err=%b cycles=%0d, required err=%b cycles=%0d",
                                         d, a, w, err, cyc, exp_err(a, w), (d == 3) ? 4 : 1);
                end
                if (w) begin
                    model_write(d, a, data, s);
                end else begin
                    n_checks++;
                    if (rd !== (exp_err(a, 1'b0) ? 32'd0 : model_read(d, a))) begin
                        n_errors++; $display("FAIL rnd_read dut%0d addr=%h: got %h, required %h", d, a, rd,
                                             exp_err(a, 1'b0) ? 32'd0 : model_read(d, a));
                    end
                end
            end
            repeat ($urandom_range(0, 2)) @(posedge pclk);
            #0;
        end
    endtask

    initial begin
        prst = 1'b1;
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        @(posedge pclk); #1;
        test_reset();
        test_zero_wait();
        test_strobes();
        test_wait_states();
        test_errors();
        test_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
